// File: rtl/code_checker.sv
// Four-nibble entry code checker: compares a keyed-in hex code against `key`.
// A correct code opens a timed unlock window; too many wrong codes cause a timed lockout.
module code_checker #(
  parameter int unsigned MAX_FAILS     = 3,
  parameter int unsigned UNLOCK_CYCLES = 8,
  parameter int unsigned LOCK_CYCLES   = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] key,
  input  logic        digit_valid,
  input  logic [3:0]  digit,
  input  logic        cancel,
  output logic        unlock,
  output logic        fail_pulse,
  output logic        locked,
  output logic [2:0]  digit_count,
  output logic [2:0]  fail_count
);

  localparam int unsigned TMAX = (UNLOCK_CYCLES > LOCK_CYCLES) ? UNLOCK_CYCLES : LOCK_CYCLES;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] UNLOCK_LOAD = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LOAD   = TW'(LOCK_CYCLES - 1);
  localparam logic [3:0]    MAX_FAILS_4 = 4'(MAX_FAILS);

  typedef enum logic [1:0] {ENTRY, CHECK, UNLOCKED, LOCKOUT} state_e;

  state_e        state_q, state_d;
  logic [15:0]   entry_q, entry_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [2:0]    fails_q, fails_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          unlock_q, unlock_d;
  logic          fail_pulse_q, fail_pulse_d;
  logic          locked_q, locked_d;
  logic [3:0]    fails_next;

  assign fails_next = {1'b0, fails_q} + 4'd1;

  always_comb begin
    state_d      = state_q;
    entry_d      = entry_q;
    cnt_d        = cnt_q;
    fails_d      = fails_q;
    timer_d      = timer_q;
    unlock_d     = unlock_q;
    locked_d     = locked_q;
    fail_pulse_d = 1'b0;
    unique case (state_q)
      ENTRY: begin
        if (cancel) begin
          entry_d = '0;
          cnt_d   = '0;
        end else if (digit_valid) begin
          entry_d = {entry_q[11:0], digit};
          if (cnt_q == 3'd3) begin
            cnt_d   = '0;
            state_d = CHECK;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      CHECK: begin
        // key is sampled only here, so earlier key changes have no effect
        entry_d = '0;
        if (entry_q == key) begin
          state_d  = UNLOCKED;
          unlock_d = 1'b1;
          fails_d  = '0;
          timer_d  = UNLOCK_LOAD;
        end else begin
          fail_pulse_d = 1'b1;
          if (fails_next < MAX_FAILS_4) begin
            fails_d = fails_next[2:0];
            state_d = ENTRY;
          end else begin
            fails_d  = MAX_FAILS_4[2:0];
            state_d  = LOCKOUT;
            locked_d = 1'b1;
            timer_d  = LOCK_LOAD;
          end
        end
      end
      UNLOCKED: begin
        if (cancel || timer_q == '0) begin
          state_d  = ENTRY;
          unlock_d = 1'b0;
          timer_d  = '0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      LOCKOUT: begin
        if (timer_q == '0) begin
          state_d  = ENTRY;
          locked_d = 1'b0;
          fails_d  = '0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = ENTRY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ENTRY;
      entry_q      <= '0;
      cnt_q        <= '0;
      fails_q      <= '0;
      timer_q      <= '0;
      unlock_q     <= 1'b0;
      fail_pulse_q <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      entry_q      <= entry_d;
      cnt_q        <= cnt_d;
      fails_q      <= fails_d;
      timer_q      <= timer_d;
      unlock_q     <= unlock_d;
      fail_pulse_q <= fail_pulse_d;
      locked_q     <= locked_d;
    end
  end

  assign unlock      = unlock_q;
  assign fail_pulse  = fail_pulse_q;
  assign locked      = locked_q;
  assign digit_count = cnt_q;
  assign fail_count  = fails_q;

endmodule

// File: tb/tb_code_checker.sv
// Bench for code_checker: directed scenarios plus random traffic, every cycle
// compared against a queue/countdown model of the lock's behaviour.
module tb_code_checker;

  localparam int MF = 3;
  localparam int UC = 8;
  localparam int LC = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] key = 16'h0000;
  logic        digit_valid = 1'b0;
  logic [3:0]  digit = 4'h0;
  logic        cancel = 1'b0;
  logic        unlock, fail_pulse, locked;
  logic [2:0]  digit_count, fail_count;

  code_checker #(.MAX_FAILS(MF), .UNLOCK_CYCLES(UC), .LOCK_CYCLES(LC)) dut (
    .clk(clk), .reset_n(reset_n), .key(key), .digit_valid(digit_valid),
    .digit(digit), .cancel(cancel), .unlock(unlock), .fail_pulse(fail_pulse),
    .locked(locked), .digit_count(digit_count), .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Model: accepted nibbles, pending comparison, remaining window lengths.
  int          m_digits[$];
  bit          m_checking;
  logic [15:0] m_code;
  int          m_unl, m_lck, m_fails;
  bit          m_pulse;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void m_reset();
    m_digits.delete();
    m_checking = 0;
    m_code     = '0;
    m_unl      = 0;
    m_lck      = 0;
    m_fails    = 0;
    m_pulse    = 0;
  endfunction

  function automatic void model_step();
    bit p = 0;
    if (m_checking) begin
      m_checking = 0;
      if (m_code == key) begin
        m_fails = 0;
        m_unl   = UC;
      end else begin
        p = 1;
        m_fails++;
        if (m_fails == MF) m_lck = LC;
      end
    end else if (m_unl > 0) begin
      m_unl = cancel ? 0 : m_unl - 1;
    end else if (m_lck > 0) begin
      m_lck--;
      if (m_lck == 0) m_fails = 0;
    end else if (cancel) begin
      m_digits.delete();
    end else if (digit_valid) begin
      m_digits.push_back(int'(digit));
      if (m_digits.size() == 4) begin
        m_code = 16'((m_digits[0] << 12) | (m_digits[1] << 8) | (m_digits[2] << 4) | m_digits[3]);
        m_digits.delete();
        m_checking = 1;
      end
    end
    m_pulse = p;
  endfunction

  function automatic void compare_all();
    chk("unlock", unlock, (m_unl > 0));
    chk("locked", locked, (m_lck > 0));
    chk("fail_pulse", fail_pulse, m_pulse);
    chk("digit_count", digit_count, m_digits.size());
    chk("fail_count", fail_count, m_fails);
  endfunction

  task automatic tick(input logic dv, input logic [3:0] d, input logic c);
    digit_valid = dv;
    digit       = d;
    cancel      = c;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 4'h0, 1'b0);
  endtask

  task automatic enter(input logic [15:0] c);
    for (int i = 0; i < 4; i++) tick(1'b1, c[15-4*i -: 4], 1'b0);
  endtask

  // Called just after a negedge: pulses reset between clock edges.
  task automatic reset_pulse();
    #2 reset_n = 1'b0;
    #1;
    m_reset();
    chk("rst_locked", locked, 1'b0);
    chk("rst_unlock", unlock, 1'b0);
    chk("rst_fail_count", fail_count, 3'd0);
    chk("rst_digit_count", digit_count, 3'd0);
    chk("rst_fail_pulse", fail_pulse, 1'b0);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    int n;
    m_reset();
    #3;
    compare_all();
    @(negedge clk);
    reset_n = 1'b1;

    // correct code
    key = 16'hA5C3;
    enter(16'hA5C3);
    chk("cc_unlock_early", unlock, 1'b0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      idle(1);
      if (i == 0) chk("cc_unlock_latency", unlock, 1'b1);
      n += int'(unlock);
    end
    chk("cc_unlock_cycles", n, UC);

    // lockout
    key = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      logic [15:0] c;
      c = {4{4'(i + 1)}};
      enter(c);
      idle(1);
      chk("lo_fail_pulse", fail_pulse, 1'b1);
      chk("lo_fail_count", fail_count, 3'(i + 1));
    end
    chk("lo_locked", locked, 1'b1);
    n = 1;
    for (int i = 0; i < LC - 1; i++) begin
      tick(1'b1, 4'h5, 1'b0);
      n += int'(locked);
    end
    chk("lo_lock_cycles", n, LC);
    chk("lo_digits_ignored", digit_count, 3'd0);
    idle(1);
    chk("lo_released", locked, 1'b0);
    chk("lo_fail_cleared", fail_count, 3'd0);
    enter(16'h1234);
    idle(1);
    chk("lo_then_unlock", unlock, 1'b1);
    idle(10);

    // cancel has priority over a same-cycle digit
    tick(1'b1, 4'h1, 1'b0);
    tick(1'b1, 4'h2, 1'b0);
    tick(1'b1, 4'h3, 1'b1);
    chk("cn_digit_count", digit_count, 3'd0);
    enter(16'h1234);
    idle(1);
    chk("cn_unlock", unlock, 1'b1);
    tick(1'b0, 4'h0, 1'b1);
    chk("cn_cancel_unlock", unlock, 1'b0);

    // key change before the last digit
    key = 16'h1234;
    tick(1'b1, 4'h1, 1'b0);
    tick(1'b1, 4'h2, 1'b0);
    tick(1'b1, 4'h3, 1'b0);
    key = 16'h1239;
    tick(1'b1, 4'h9, 1'b0);
    idle(1);
    chk("kc_unlock", unlock, 1'b1);
    idle(10);

    // failure count clears on success
    key = 16'h1234;
    enter(16'h1111);
    idle(1);
    chk("fr_fail1", fail_count, 3'd1);
    enter(16'h1234);
    idle(1);
    chk("fr_unlock", unlock, 1'b1);
    chk("fr_fail0", fail_count, 3'd0);
    idle(10);
    enter(16'h2222); idle(1);
    enter(16'h3333); idle(1);
    chk("fr_fail2", fail_count, 3'd2);
    chk("fr_not_locked", locked, 1'b0);
    enter(16'h1234); idle(UC + 2);

    // zero key
    key = 16'h0000;
    enter(16'h0000);
    idle(1);
    chk("zk_unlock", unlock, 1'b1);
    idle(10);

    // reset mid-lockout
    key = 16'h1234;
    for (int i = 0; i < 3; i++) begin enter(16'h5555); idle(1); end
    idle(5);
    chk("rl_locked_before", locked, 1'b1);
    reset_pulse();
    tick(1'b1, 4'h1, 1'b0);
    chk("rl_first_digit", digit_count, 3'd1);
    tick(1'b1, 4'h2, 1'b0);
    tick(1'b1, 4'h3, 1'b0);
    tick(1'b1, 4'h4, 1'b0);
    idle(1);
    chk("rl_unlock", unlock, 1'b1);
    idle(3);
    reset_pulse();
    idle(3);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      logic [3:0]  d;
      logic [15:0] k;
      int          pos;
      if ($urandom_range(99) < 2) begin
        case ($urandom_range(3))
          0: key = 16'h1234;
          1: key = 16'h0000;
          2: key = 16'hA5C3;
          default: key = 16'hFFFF;
        endcase
      end
      if ($urandom_range(599) == 0) reset_pulse();
      pos = m_digits.size();
      k   = key >> (12 - 4 * (pos % 4));
      d   = ($urandom_range(4) != 0) ? k[3:0] : 4'($urandom_range(15));
      tick(($urandom_range(3) != 0), d, ($urandom_range(29) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/code_checker.md
CODE_CHECKER -- requirements
Module: code_checker

Interface
REQ-001 The block SHALL have the parameter MAX_FAILS, default 3, meaning the number of consecutive wrong codes that triggers lockout (range 1..7).
REQ-002 The block SHALL have the parameter UNLOCK_CYCLES, default 8, meaning how many cycles unlock is held high after a correct code (>=1).
REQ-003 The block SHALL have the parameter LOCK_CYCLES, default 16, meaning how many cycles lockout lasts (>=1).
REQ-004 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have the port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have the port key, input, 16 bits: the stored secret key, driven by the secret key register.
REQ-007 The block SHALL have the port digit_valid, input, 1 bit: qualifies digit for one cycle.
REQ-008 The block SHALL have the port digit, input, 4 bits: one entered hex nibble, most significant nibble entered first.
REQ-009 The block SHALL have the port cancel, input, 1 bit: abandons the current entry or unlock window.
REQ-010 The block SHALL have the port unlock, output, 1 bit: high while the unlock window is open.
REQ-011 The block SHALL have the port fail_pulse, output, 1 bit: one-cycle pulse per wrong code.
REQ-012 The block SHALL have the port locked, output, 1 bit: high during lockout.
REQ-013 The block SHALL have the port digit_count, output, 3 bits: number of nibbles accepted in the current entry (0..3).
REQ-014 The block SHALL have the port fail_count, output, 3 bits: number of consecutive wrong codes so far.

Function
REQ-015 The block SHALL implement the states ENTRY, CHECK, UNLOCKED and LOCKOUT, and all outputs SHALL be registered.
REQ-016 In ENTRY, when digit_valid is high and cancel is low, the block SHALL update entry to {entry[11:0], digit} and increment digit_count.
REQ-017 When digit_valid is accepted with digit_count==3, the block SHALL go to CHECK on the next edge, and digit_count SHALL return to 0.
REQ-018 In CHECK (exactly one cycle), the block SHALL compare entry to the key value present in that cycle; any change to key earlier in the entry SHALL be ignored.
REQ-019 On a match, the block SHALL go to UNLOCKED, clear fail_count, and raise unlock on the same edge.
- With the 4th digit accepted at edge N, unlock SHALL be high from edge N+2.
- unlock SHALL stay high for exactly UNLOCK_CYCLES cycles.
REQ-020 On a mismatch where fail_count+1 < MAX_FAILS, the block SHALL increment fail_count, pulse fail_pulse high for exactly one cycle starting at edge N+2, and return to ENTRY.
REQ-021 On a mismatch where fail_count+1 == MAX_FAILS, the block SHALL pulse fail_pulse, set fail_count to MAX_FAILS, go to LOCKOUT, and raise locked from edge N+2.
- locked SHALL stay high for exactly LOCK_CYCLES cycles.
- The block SHALL then return to ENTRY with fail_count=0.
REQ-022 When UNLOCK_CYCLES expire, the block SHALL return to ENTRY with unlock low; fail_count SHALL remain 0.
REQ-023 cancel handling:
- In ENTRY, cancel SHALL clear entry and digit_count, and SHALL take priority over digit_valid in the same cycle.
- In UNLOCKED, cancel SHALL drop unlock on the next edge and return to ENTRY.
- In CHECK and LOCKOUT, cancel SHALL be ignored.
REQ-024 digit_valid SHALL be ignored in CHECK, UNLOCKED and LOCKOUT; ignored nibbles SHALL NOT be buffered.
REQ-025 On entering ENTRY from any state, entry SHALL be 16'h0000 and digit_count SHALL be 0.
REQ-026 key==16'h0000 SHALL NOT be a special case: entering 0,0,0,0 SHALL unlock.
REQ-027 unlock and locked SHALL never be high in the same cycle.

Reset
REQ-028 When reset_n is low, the block SHALL immediately, asynchronously to clk, force state=ENTRY, entry=0, digit_count=0, fail_count=0, unlock=0, fail_pulse=0, locked=0, and clear all timers.
REQ-029 A reset asserted mid-entry, mid-unlock or mid-lockout SHALL abort that operation with no residual pulse after release.
REQ-030 After reset_n rises, the first clk edge SHALL be able to accept a digit.

Verification
REQ-031 Test "correct code": key=16'hA5C3; digits A,5,C,3 on consecutive cycles -> unlock high 2 cycles after the last digit for 8 cycles; fail_pulse stays 0.
REQ-032 Test "lockout": key=16'h1234; codes 1111, 2222, 3333 -> fail_pulse once after each code; fail_count goes 1, 2, 3; locked high for 16 cycles; digits during lockout are ignored; afterwards 1,2,3,4 unlocks.
REQ-033 Test "cancel": digits 1,2 then cancel with digit_valid=1 and digit=3 in the same cycle -> digit_count=0; then 1,2,3,4 -> unlock.
REQ-034 Test "key change": key=16'h1234, digits 1,2,3, then key changes to 16'h1239 before the 4th digit 9 -> unlock, because the key is sampled at CHECK.
REQ-035 Test "failure reset": one wrong code (fail_count=1), then the correct code -> unlock and fail_count=0; two further wrong codes do not lock out.
REQ-036 Test "reset mid-lockout": reset_n pulsed low mid-lockout -> locked=0 immediately (asynchronously), fail_count=0, and the next entry works normally.
